// File: rtl/branch_resolve_bht_pkg.sv
// Shared types and helpers for the MEM-stage branch resolver and its BHT.
// Optional performance counters are enabled with the BRANCH_PERF_CNT_EN macro.
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef logic [1:0] bht_ctr_t;
  localparam bht_ctr_t WEAK_NT = 2'b01;

  typedef enum logic {IDLE, FLUSH} flush_state_t;

  // funct3 2/3 are not branch encodings, so they resolve as never taken.
  function automatic logic eval_cond(input logic [2:0] funct3, input logic zero, input logic lt);
    logic res;
    res = 1'b0;
    case (funct3)
      BEQ:        res = zero;
      BNE:        res = ~zero;
      BLT, BLTU:  res = lt;
      BGE, BGEU:  res = ~lt;
      default:    res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic bht_ctr_t ctr_update(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t nxt;
    if (taken) nxt = (ctr == 2'b11) ? ctr : ctr + 2'b01;
    else       nxt = (ctr == 2'b00) ? ctr : ctr - 2'b01;
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_bht_if.sv
// Bundle of MEM-stage inputs, fetch lookup and redirect/flush outputs of the resolver.
// Performance counter signals exist only when BRANCH_PERF_CNT_EN is defined.
interface branch_resolve_bht_if #(parameter int XLEN = 32);

  logic            io_mem_valid;
  logic [XLEN-1:0] io_mem_pc;
  logic [XLEN-1:0] io_mem_target;
  logic            io_mem_zero;
  logic [XLEN-1:0] io_mem_aluresult;
  logic [2:0]      io_mem_funct3;
  logic            io_mem_isbranch;
  logic            io_mem_isjump;
  logic            io_mem_predtaken;
  logic [XLEN-1:0] io_if_pc;
  logic            io_if_predtaken;
  logic            io_branch;
  logic            io_pcsrc;
  logic            io_redirect;
  logic [XLEN-1:0] io_redirect_pc;
  logic            io_flush;
`ifdef BRANCH_PERF_CNT_EN
  logic [31:0]     io_perf_branches;
  logic [31:0]     io_perf_mispredicts;
`endif

  modport master (
    output io_mem_valid, io_mem_pc, io_mem_target, io_mem_zero, io_mem_aluresult,
           io_mem_funct3, io_mem_isbranch, io_mem_isjump, io_mem_predtaken, io_if_pc,
`ifdef BRANCH_PERF_CNT_EN
    input  io_perf_branches, io_perf_mispredicts,
`endif
    input  io_if_predtaken, io_branch, io_pcsrc, io_redirect, io_redirect_pc, io_flush
  );

  modport slave (
    input  io_mem_valid, io_mem_pc, io_mem_target, io_mem_zero, io_mem_aluresult,
           io_mem_funct3, io_mem_isbranch, io_mem_isjump, io_mem_predtaken, io_if_pc,
`ifdef BRANCH_PERF_CNT_EN
    output io_perf_branches, io_perf_mispredicts,
`endif
    output io_if_predtaken, io_branch, io_pcsrc, io_redirect, io_redirect_pc, io_flush
  );

endinterface

// File: rtl/branch_resolve_bht_table.sv
// Branch history table: array of 2-bit saturating counters, one async read, one update port.
module bht_table
  import branch_pkg::*;
#(
  parameter int ENTRIES = 64,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_ctr_t         rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  bht_ctr_t table_q [ENTRIES];

  // Read sees the registered contents, so a same-cycle update is not bypassed.
  assign rd_ctr = table_q[rd_idx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= WEAK_NT;
      end
    end else if (upd_en) begin
      table_q[upd_idx] <= ctr_update(table_q[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/branch_resolve_bht.sv
// MEM-stage branch resolver: evaluates branches, trains the BHT, issues redirect and flush.
// Define BRANCH_PERF_CNT_EN to add saturating branch/mispredict counters.
module branch_resolve_bht
  import branch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int BHT_ENTRIES  = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input logic                clock,
  input logic                reset,
  branch_resolve_bht_if.slave bus
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  flush_state_t    state;
  logic [2:0]      flush_cnt;
  logic            redirect_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic            flush_q;

  logic            eff_valid;
  logic            cond;
  logic            taken;
  logic            mispredict;
  logic            upd_en;
  logic [XLEN-1:0] correct_pc;
  bht_ctr_t        rd_ctr;
  logic            unused_bits;

  // The instruction in MEM during a flush is wrong-path and must not act.
  assign eff_valid  = bus.io_mem_valid & (state == IDLE);
  assign cond       = eval_cond(bus.io_mem_funct3, bus.io_mem_zero, bus.io_mem_aluresult[0]);
  assign taken      = bus.io_mem_isjump | (bus.io_mem_isbranch & cond);
  assign mispredict = eff_valid & (bus.io_mem_isbranch | bus.io_mem_isjump)
                      & (taken != bus.io_mem_predtaken);
  assign upd_en     = eff_valid & bus.io_mem_isbranch;
  assign correct_pc = taken ? bus.io_mem_target : bus.io_mem_pc + XLEN'(4);

  assign unused_bits = ^{bus.io_mem_aluresult[XLEN-1:1], bus.io_if_pc[XLEN-1:IDX_W+2],
                         bus.io_if_pc[1:0]};

  bht_table #(.ENTRIES(BHT_ENTRIES)) u_bht (
    .clock     (clock),
    .reset     (reset),
    .rd_idx    (bus.io_if_pc[IDX_W+1:2]),
    .rd_ctr    (rd_ctr),
    .upd_en    (upd_en),
    .upd_idx   (bus.io_mem_pc[IDX_W+1:2]),
    .upd_taken (taken)
  );

  assign bus.io_if_predtaken = rd_ctr[1];
  assign bus.io_branch       = bus.io_mem_valid & bus.io_mem_isbranch;
  assign bus.io_pcsrc        = eff_valid & taken;
  assign bus.io_redirect     = redirect_q;
  assign bus.io_redirect_pc  = redirect_pc_q;
  assign bus.io_flush        = flush_q;

  // flush_q is set on entry to FLUSH and cleared on the exit edge, giving FLUSH_CYCLES high cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      flush_cnt     <= 3'd0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      flush_q       <= 1'b0;
    end else begin
      redirect_q <= mispredict;
      if (mispredict) begin
        redirect_pc_q <= correct_pc;
      end
      case (state)
        IDLE: begin
          if (mispredict) begin
            state     <= FLUSH;
            flush_cnt <= 3'(FLUSH_CYCLES - 1);
            flush_q   <= 1'b1;
          end
        end
        FLUSH: begin
          if (flush_cnt == 3'd0) begin
            state   <= IDLE;
            flush_q <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        default: begin
          state   <= IDLE;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] perf_br_q;
  logic [31:0] perf_mis_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_br_q  <= 32'd0;
      perf_mis_q <= 32'd0;
    end else begin
      if (upd_en && (perf_br_q != 32'hFFFF_FFFF)) begin
        perf_br_q <= perf_br_q + 32'd1;
      end
      if (mispredict && (perf_mis_q != 32'hFFFF_FFFF)) begin
        perf_mis_q <= perf_mis_q + 32'd1;
      end
    end
  end

  assign bus.io_perf_branches    = perf_br_q;
  assign bus.io_perf_mispredicts = perf_mis_q;
`endif

endmodule
